// File: rtl/avmm_pkg.sv
// Shared Avalon-MM definitions: data word type, address conversion and
// parameter legalisation used by the memory responder and its read pipe.
package avmm_pkg;

  typedef logic [31:0] avmm_word_t;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 8;

  // Out-of-range latencies are pulled into 1..8 so an instance always elaborates.
  function automatic int legal_latency(int lat);
    if (lat < LATENCY_MIN) return LATENCY_MIN;
    if (lat > LATENCY_MAX) return LATENCY_MAX;
    return lat;
  endfunction

  // Pending limit is held to 1..latency; the default pairing (4 vs 3) becomes 3.
  function automatic int legal_pending(int max_pending, int lat);
    if (max_pending < 1) return 1;
    if (max_pending > lat) return lat;
    return max_pending;
  endfunction

  // Byte address to word address; the low two bits select a byte lane and are dropped.
  function automatic avmm_word_t byte_to_word(avmm_word_t byte_addr);
    return {2'b00, byte_addr[31:2]};
  endfunction

endpackage

// File: rtl/avmm_rd_pipe.sv
// Read-return delay line: LATENCY stage-valid bits plus the matching data
// stages. Stage 0 data is the RAM output register, loaded at the accepting edge.
module avmm_rd_pipe
  import avmm_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  avmm_word_t in_data,
  output logic       launch,
  output logic       out_valid,
  output avmm_word_t out_data
);

  logic [LATENCY-1:0] stage_vld;
  logic [LATENCY:0]   vld_chain;
  avmm_word_t         tail_data;

  assign vld_chain = {stage_vld, in_valid};
  // launch is the value the output stage loads at the next edge.
  assign launch    = vld_chain[LATENCY-1];
  assign out_valid = vld_chain[LATENCY];

  // Shift the valid bits; reset discards every read still in flight.
  always_ff @(posedge clk) begin
    if (rst) stage_vld <= '0;
    else     stage_vld <= vld_chain[LATENCY-1:0];
  end

  if (LATENCY == 1) begin : g_no_delay
    assign tail_data = in_data;
  end else begin : g_delay
    avmm_word_t dly [LATENCY-1];
    // Data follows its valid bit; no reset needed since the output is gated.
    always_ff @(posedge clk) begin
      dly[0] <= in_data;
      for (int k = 1; k < LATENCY - 1; k++) dly[k] <= dly[k-1];
    end
    assign tail_data = dly[LATENCY-2];
  end

  assign out_data = out_valid ? tail_data : '0;

endmodule

// File: rtl/avmm_mem_responder.sv
// Pipelined variable-latency Avalon-MM memory responder: single-port RAM,
// fixed read latency, bounded outstanding reads and a sticky protocol error.
module avmm_mem_responder
  import avmm_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int LATENCY     = 3,
  parameter int MAX_PENDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        slave_waitrequest,
  input  logic [31:0] slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  output logic        slave_readdatavalid,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  output logic        protocol_error
);

  localparam int          LAT       = legal_latency(LATENCY);
  localparam int          MPE       = legal_pending(MAX_PENDING, LAT);
  localparam logic [3:0]  PEND_FULL = 4'(MPE);

  logic [3:0]            pending;
  logic                  req_ok;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  collision;
  logic                  rd_launch;
  avmm_word_t            word_addr;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  unused_addr_bits;
  avmm_word_t            ram_q;
  avmm_word_t            mem [1 << DEPTH_LOG2];

  assign slave_waitrequest = (pending == PEND_FULL);
  assign req_ok            = !rst && !slave_waitrequest;
  assign wr_acc            = req_ok && slave_write;
  assign rd_acc            = req_ok && slave_read && !slave_write;
  assign collision         = req_ok && slave_read && slave_write;

  assign word_addr        = byte_to_word(slave_address);
  assign word_idx         = word_addr[DEPTH_LOG2-1:0];
  assign unused_addr_bits = ^word_addr[31:DEPTH_LOG2];

  // Single-port RAM, read-first; memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[word_idx] <= slave_writedata;
    ram_q <= mem[word_idx];
  end

  // A read stops counting at the edge that launches its readdatavalid, so a
  // pending limit equal to the latency still accepts one read every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      case ({rd_acc, rd_launch})
        2'b10:   pending <= pending + 4'd1;
        2'b01:   pending <= pending - 4'd1;
        default: pending <= pending;
      endcase
    end
  end

  // Simultaneous read and write: the write wins and the error latches until reset.
  always_ff @(posedge clk) begin
    if (rst)            protocol_error <= 1'b0;
    else if (collision) protocol_error <= 1'b1;
  end

  avmm_rd_pipe #(
    .LATENCY(LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_acc),
    .in_data  (ram_q),
    .launch   (rd_launch),
    .out_valid(slave_readdatavalid),
    .out_data (slave_readdata)
  );

endmodule

// File: tb/tb_avmm_mem_responder.sv
// Directed bench over four responder configurations:
//   0: defaults (L=3), 1: L=4/MP=4, 2: L=4/MP=2, 3: L=1/MP=1.
module tb_avmm_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rd = '0, wr = '0;
  logic [3:0]  wreq, rvalid, perr;
  logic [31:0] addr [4];
  logic [31:0] wdata [4];
  logic [31:0] rdata [4];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  avmm_mem_responder u_dut0 (
    .clk(clk), .rst(rst), .slave_waitrequest(wreq[0]), .slave_address(addr[0]),
    .slave_read(rd[0]), .slave_readdata(rdata[0]), .slave_readdatavalid(rvalid[0]),
    .slave_write(wr[0]), .slave_writedata(wdata[0]), .protocol_error(perr[0]));

  avmm_mem_responder #(.DEPTH_LOG2(10), .LATENCY(4), .MAX_PENDING(4)) u_dut1 (
    .clk(clk), .rst(rst), .slave_waitrequest(wreq[1]), .slave_address(addr[1]),
    .slave_read(rd[1]), .slave_readdata(rdata[1]), .slave_readdatavalid(rvalid[1]),
    .slave_write(wr[1]), .slave_writedata(wdata[1]), .protocol_error(perr[1]));

  avmm_mem_responder #(.DEPTH_LOG2(10), .LATENCY(4), .MAX_PENDING(2)) u_dut2 (
    .clk(clk), .rst(rst), .slave_waitrequest(wreq[2]), .slave_address(addr[2]),
    .slave_read(rd[2]), .slave_readdata(rdata[2]), .slave_readdatavalid(rvalid[2]),
    .slave_write(wr[2]), .slave_writedata(wdata[2]), .protocol_error(perr[2]));

  avmm_mem_responder #(.DEPTH_LOG2(10), .LATENCY(1), .MAX_PENDING(1)) u_dut3 (
    .clk(clk), .rst(rst), .slave_waitrequest(wreq[3]), .slave_address(addr[3]),
    .slave_read(rd[3]), .slave_readdata(rdata[3]), .slave_readdatavalid(rvalid[3]),
    .slave_write(wr[3]), .slave_writedata(wdata[3]), .protocol_error(perr[3]));

  task automatic drive(input int d, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] wd);
    rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 4; d++) drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic write_word(input int d, input logic [31:0] a, input logic [31:0] wd);
    drive(d, 1'b0, 1'b1, a, wd);
    @(negedge clk);
    drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 4; d++) drive(d, 1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk); @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      vectors++;
      if (rvalid[d] !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid dut%0d got %b want 0", d, rvalid[d]); end
      vectors++;
      if (rdata[d] !== 32'h0) begin miscompares++; $display("FAIL reset_rdata dut%0d got %h want 0", d, rdata[d]); end
      vectors++;
      if (wreq[d] !== 1'b0) begin miscompares++; $display("FAIL reset_waitreq dut%0d got %b want 0", d, wreq[d]); end
      vectors++;
      if (perr[d] !== 1'b0) begin miscompares++; $display("FAIL reset_perr dut%0d got %b want 0", d, perr[d]); end
    end
    rst = 1'b0;
    idle_all();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      vectors++;
      if (rvalid[0] !== 1'b0) begin miscompares++; $display("FAIL reset_req_ignored k%0d got %b want 0", k, rvalid[0]); end
    end
  endtask

  task automatic test_write_read();
    for (int k = 0; k < 8; k++) begin
      if (k >= 2) begin
        vectors++;
        if (rvalid[0] !== (k == 4)) begin miscompares++; $display("FAIL wr_rd_valid k%0d got %b want %b", k, rvalid[0], (k == 4)); end
        vectors++;
        if (rdata[0] !== ((k == 4) ? 32'hDEADBEEF : 32'h0)) begin miscompares++; $display("FAIL wr_rd_data k%0d got %h", k, rdata[0]); end
      end
      if (k == 0)      drive(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      else if (k == 1) drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
      else             drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
    end
  endtask

  task automatic test_alias();
    for (int k = 0; k < 8; k++) begin
      if (k >= 2) begin
        vectors++;
        if (rvalid[0] !== (k == 4 || k == 5)) begin miscompares++; $display("FAIL alias_valid k%0d got %b", k, rvalid[0]); end
        vectors++;
        if (rdata[0] !== ((k == 4 || k == 5) ? 32'h1234ABCD : 32'h0)) begin miscompares++; $display("FAIL alias_data k%0d got %h want 1234abcd/0", k, rdata[0]); end
      end
      if (k == 0)      drive(0, 1'b0, 1'b1, 32'hFFFF_F004, 32'h1234ABCD);
      else if (k == 1) drive(0, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
      else if (k == 2) drive(0, 1'b1, 1'b0, 32'h0000_1004, 32'h0);
      else             drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    for (int j = 0; j < 5; j++) write_word(1, 32'(4 * j), 32'h1000_0000 + 32'(j * 'h11));
    for (int k = 0; k < 10; k++) begin
      if (k <= 4) begin
        vectors++;
        if (wreq[1] !== 1'b0) begin miscompares++; $display("FAIL b2b_stall k%0d got %b want 0", k, wreq[1]); end
      end
      exp = (k >= 4 && k <= 8) ? 32'h1000_0000 + 32'((k - 4) * 'h11) : 32'h0;
      vectors++;
      if (rvalid[1] !== (k >= 4 && k <= 8)) begin miscompares++; $display("FAIL b2b_valid k%0d got %b", k, rvalid[1]); end
      vectors++;
      if (rdata[1] !== exp) begin miscompares++; $display("FAIL b2b_data k%0d got %h want %h", k, rdata[1], exp); end
      if (k < 5) drive(1, 1'b1, 1'b0, 32'(4 * k), 32'h0);
      else       drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
    end
  endtask

  task automatic test_throttle();
    int n_valid;
    n_valid = 0;
    for (int k = 0; k < 16; k++) begin
      if (k < 12) begin
        vectors++;
        if (wreq[2] !== (k % 4 >= 2)) begin miscompares++; $display("FAIL throttle_waitreq k%0d got %b want %b", k, wreq[2], (k % 4 >= 2)); end
      end
      vectors++;
      if (rvalid[2] !== (k >= 4 && k <= 13 && (k % 4) < 2)) begin miscompares++; $display("FAIL throttle_valid k%0d got %b", k, rvalid[2]); end
      if (rvalid[2] === 1'b1) n_valid++;
      drive(2, (k < 12), 1'b0, 32'h0, 32'h0);
      @(negedge clk);
    end
    vectors++;
    if (n_valid != 6) begin miscompares++; $display("FAIL throttle_count got %0d want 6", n_valid); end
  endtask

  task automatic test_protocol_error();
    for (int k = 0; k < 10; k++) begin
      if (k >= 1) begin
        vectors++;
        if (perr[0] !== 1'b1) begin miscompares++; $display("FAIL perr_sticky k%0d got %b want 1", k, perr[0]); end
        vectors++;
        if (rvalid[0] !== (k == 8)) begin miscompares++; $display("FAIL perr_valid k%0d got %b want %b", k, rvalid[0], (k == 8)); end
        vectors++;
        if (rdata[0] !== ((k == 8) ? 32'h5 : 32'h0)) begin miscompares++; $display("FAIL perr_data k%0d got %h", k, rdata[0]); end
      end
      if (k == 0)      drive(0, 1'b1, 1'b1, 32'h20, 32'h5);
      else if (k == 5) drive(0, 1'b1, 1'b0, 32'h20, 32'h0);
      else             drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
    end
  endtask

  task automatic test_latency1();
    for (int k = 0; k < 5; k++) begin
      if (k >= 1) begin
        vectors++;
        if (wreq[3] !== 1'b0) begin miscompares++; $display("FAIL lat1_waitreq k%0d got %b want 0", k, wreq[3]); end
        vectors++;
        if (rvalid[3] !== (k == 2 || k == 3)) begin miscompares++; $display("FAIL lat1_valid k%0d got %b", k, rvalid[3]); end
        vectors++;
        if (rdata[3] !== ((k == 2 || k == 3) ? 32'h0A0B0C0D : 32'h0)) begin miscompares++; $display("FAIL lat1_data k%0d got %h", k, rdata[3]); end
      end
      if (k == 0)                drive(3, 1'b0, 1'b1, 32'h8, 32'h0A0B0C0D);
      else if (k == 1 || k == 2) drive(3, 1'b1, 1'b0, 32'h8, 32'h0);
      else                       drive(3, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_flight();
    for (int k = 0; k < 16; k++) begin
      if (k >= 1 && k <= 14) begin
        vectors++;
        if (rvalid[1] !== 1'b0) begin miscompares++; $display("FAIL flush_valid k%0d got %b want 0", k, rvalid[1]); end
      end
      if (k == 5) begin
        vectors++;
        if (perr[0] !== 1'b0) begin miscompares++; $display("FAIL perr_cleared got %b want 0", perr[0]); end
      end
      if (k == 15) begin
        vectors++;
        if (rvalid[1] !== 1'b1) begin miscompares++; $display("FAIL flush_readback_valid got %b want 1", rvalid[1]); end
        vectors++;
        if (rdata[1] !== 32'hCAFE0040) begin miscompares++; $display("FAIL flush_readback_data got %h want cafe0040", rdata[1]); end
      end
      rst = (k == 4);
      if (k == 0)                drive(1, 1'b0, 1'b1, 32'h40, 32'hCAFE0040);
      else if (k >= 1 && k <= 3) drive(1, 1'b1, 1'b0, 32'h40, 32'h0);
      else if (k == 4)           drive(1, 1'b0, 1'b1, 32'h40, 32'h00000BAD);
      else if (k == 11)          drive(1, 1'b1, 1'b0, 32'h40, 32'h0);
      else                       drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_alias();
    test_back_to_back();
    test_throttle();
    test_latency1();
    test_protocol_error();
    test_reset_mid_flight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/avmm_mem_responder.md
AVMM_MEM_RESPONDER -- requirements
Module: avmm_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the 32-bit word count.
REQ-002 SHALL have parameter LATENCY, default 3, meaning cycles from read acceptance to readdatavalid; legal range 1..8.
REQ-003 SHALL have parameter MAX_PENDING, default 4, meaning the most reads outstanding at once; legal range 1..LATENCY.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, meaning reset; it is synchronous and active-high.
REQ-006 SHALL have port slave_waitrequest, output, 1 bit, meaning the request is not accepted this cycle.
REQ-007 SHALL have port slave_address, input, 32 bits, meaning the byte address; bits [DEPTH_LOG2+1:2] index the word and all other bits are ignored.
REQ-008 SHALL have port slave_read, input, 1 bit, meaning read request.
REQ-009 SHALL have port slave_readdata, output, 32 bits, meaning returned read data.
REQ-010 SHALL have port slave_readdatavalid, output, 1 bit, meaning slave_readdata is valid this cycle.
REQ-011 SHALL have port slave_write, input, 1 bit, meaning write request.
REQ-012 SHALL have port slave_writedata, input, 32 bits, meaning the write data word.
REQ-013 SHALL have port protocol_error, output, 1 bit, meaning sticky flag for an illegal request.

Function
REQ-014 SHALL be an Avalon-MM pipelined, variable-latency responder that serves the dot/dotopt master ports as an SDRAM or SRAM-bank stand-in.
REQ-015 SHALL accept a request on any rising edge where (slave_read or slave_write) is high and slave_waitrequest is low.
REQ-016 SHALL keep a pending counter of 0..MAX_PENDING: +1 on read accept, -1 on readdatavalid, unchanged when both happen in the same cycle.
REQ-017 SHALL drive slave_waitrequest = (pending == MAX_PENDING) from registered state only, with no combinational path from slave_read or slave_write.
REQ-018 SHALL hold off both reads and writes while slave_waitrequest is high.
REQ-019 SHALL perform an accepted write to the memory word at the accepting edge.
REQ-020 SHALL sample memory for an accepted read at the accepting edge, so a write accepted one or more cycles earlier is visible to the read.
REQ-021 SHALL assert slave_readdatavalid for exactly one cycle per accepted read, starting LATENCY cycles after the accepting edge; with LATENCY=1 it is high in the cycle immediately after acceptance.
REQ-022 SHALL return read data strictly in request order.
REQ-023 SHALL sustain one read per cycle when MAX_PENDING == LATENCY.
REQ-024 SHALL drive slave_readdata to 0 whenever slave_readdatavalid is low.
REQ-025 SHALL, when read and write are both high and waitrequest is low, perform the write, drop the read, and set protocol_error.
REQ-026 SHALL, once protocol_error is set, hold it until reset.
REQ-027 SHALL have no read-data state machine beyond the delay line; control state is the pending counter plus LATENCY stage-valid bits.

Reset
REQ-028 SHALL, on rst high at a rising edge, clear pending, all stage-valid bits and protocol_error.
REQ-029 SHALL, in the cycle after reset, drive slave_readdatavalid=0, slave_readdata=0 and slave_waitrequest=0.
REQ-030 SHALL discard in-flight reads when reset occurs mid-operation; they never produce readdatavalid.
REQ-031 SHALL NOT clear memory contents on reset.
REQ-032 SHALL ignore requests presented in a reset cycle.

Structure
REQ-033 SHALL take the 32-bit word typedef, byte-to-word address conversion, and LATENCY/MAX_PENDING range checks from shared package avmm_pkg.
REQ-034 SHALL place the LATENCY-deep valid/data delay line in one sub-module, avmm_rd_pipe.
REQ-035 SHALL infer the memory as a single-port synchronous RAM.

Verification
REQ-036 SHALL cover: write 0xDEADBEEF to 0x10, then read 0x10 on the next cycle (LATENCY=3) -> readdatavalid with 0xDEADBEEF exactly 3 cycles after acceptance.
REQ-037 SHALL cover: back-to-back reads of 0x0, 0x4, 0x8, 0xC, 0x10 with MAX_PENDING=4, LATENCY=4 -> no stall, five in-order valids on consecutive cycles.
REQ-038 SHALL cover: MAX_PENDING=2, LATENCY=4, continuous reads -> waitrequest high after 2 accepts and throughput of 2 reads per 4 cycles.
REQ-039 SHALL cover: read and write both high at address 0x20, data 0x5 -> word 8 = 0x5, no readdatavalid, protocol_error=1 until rst.
REQ-040 SHALL cover: rst pulsed with 3 reads in flight -> zero readdatavalid afterwards, and a prior write at 0x40 still reads back.
REQ-041 SHALL cover: address 0xFFFF_F004 with DEPTH_LOG2=10 -> aliases word 1.
